// File: rtl/wasca_led_pkg.sv
// Shared types and constants for the wasca LED pattern stage.
// Optional gamma-corrected duty is enabled with WASCA_LED_GAMMA_EN.
package wasca_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_FOLLOW   = 2'd1,
    MODE_BLINK    = 2'd2,
    MODE_FORCE_ON = 2'd3
  } led_mode_t;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_DUTY     = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam logic [1:0] CTRL_RST_MODE = MODE_FOLLOW;
  localparam logic [7:0] DUTY_RST      = 8'hFF;

endpackage

// File: rtl/wasca_led_tick_gen.sv
// Prescaler for the LED stage: PRESCALE register, counter and tick pulse.
// A PRESCALE write restarts the count and drops that cycle's tick.
module wasca_led_tick_gen #(
  parameter int unsigned           PRESCALE_W       = 16,
  parameter logic [PRESCALE_W-1:0] DEFAULT_PRESCALE = 16'd49999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [PRESCALE_W-1:0] wdata,
  output logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] presc_cnt;
  logic                  hit;

  assign hit = (presc_cnt == prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale  <= DEFAULT_PRESCALE;
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else if (wr) begin
      prescale  <= wdata;
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else begin
      tick      <= hit;
      presc_cnt <= hit ? '0 : presc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wasca_led_pattern.sv
// LED pattern stage: per-LED mode, PWM brightness and blink between PIO and pins.
// Define WASCA_LED_GAMMA_EN for a registered, squared duty curve.
module wasca_led_pattern
  import wasca_led_pkg::*;
#(
  parameter int unsigned           NUM_LEDS         = 4,
  parameter int unsigned           PRESCALE_W       = 16,
  parameter logic [PRESCALE_W-1:0] DEFAULT_PRESCALE = 16'd49999,
  parameter int unsigned           PWM_W            = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int unsigned CW = 2 * NUM_LEDS;

  logic                  wr;
  logic [CW-1:0]         ctrl;
  logic [PWM_W-1:0]      duty;
  logic [PWM_W-1:0]      duty_eff;
  logic [PWM_W-1:0]      pwm_cnt;
  logic                  blink_phase;
  logic                  pwm_on;
  logic                  tick;
  logic [PRESCALE_W-1:0] prescale;
  logic [NUM_LEDS-1:0]   led_nxt;
  logic                  unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  wasca_led_tick_gen #(
    .PRESCALE_W      (PRESCALE_W),
    .DEFAULT_PRESCALE(DEFAULT_PRESCALE)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr && (address == ADDR_PRESCALE)),
    .wdata   (writedata[PRESCALE_W-1:0]),
    .prescale(prescale),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= {NUM_LEDS{CTRL_RST_MODE}};
      duty <= PWM_W'(DUTY_RST);
    end else begin
      if (wr && (address == ADDR_CTRL))
        ctrl <= writedata[CW-1:0];
      if (wr && (address == ADDR_DUTY))
        duty <= writedata[PWM_W-1:0];
    end
  end

  // Blink phase flips on the tick that wraps the PWM counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (&pwm_cnt)
        blink_phase <= ~blink_phase;
    end
  end

`ifdef WASCA_LED_GAMMA_EN
  logic [2*PWM_W-1:0] duty_sq;

  assign duty_sq = {{PWM_W{1'b0}}, duty} * {{PWM_W{1'b0}}, duty};

  always_ff @(posedge clk) begin
    if (reset)
      duty_eff <= PWM_W'(DUTY_RST);
    else
      duty_eff <= (&duty) ? '1 : duty_sq[2*PWM_W-1:PWM_W];
  end
`else
  assign duty_eff = duty;
`endif

  assign pwm_on = (&duty_eff) | (pwm_cnt < duty_eff);

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      unique case (led_mode_t'(ctrl[2*i +: 2]))
        MODE_OFF:      led_nxt[i] = 1'b0;
        MODE_FOLLOW:   led_nxt[i] = led_in[i] & pwm_on;
        MODE_BLINK:    led_nxt[i] = led_in[i] & blink_phase & pwm_on;
        MODE_FORCE_ON: led_nxt[i] = pwm_on;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      led_out <= '0;
    else
      led_out <= led_nxt;
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_CTRL:     readdata = 32'(ctrl);
      ADDR_PRESCALE: readdata = 32'(prescale);
      ADDR_DUTY:     readdata = 32'(duty);
      ADDR_STATUS:   readdata = 32'({blink_phase, pwm_cnt});
    endcase
  end

endmodule
